// File: rtl/reg_bank_dumper_pkg.sv
// Shared definitions for the register-bank read-out engine: default bank geometry
// and the dump FSM state encoding.
package reg_bank_dumper_pkg;

  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = 5;
  localparam int DW_DEF   = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2,
    ST_FIN  = 2'd3
  } dump_state_e;

endpackage

// File: rtl/reg_bank_dumper.sv
// Walks a register address range of the bank, streaming {address, data} words over
// valid/ready while holding the core frozen; pulses done once the last word is taken.
module reg_bank_dumper
  import reg_bank_dumper_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] first_addr,
  input  logic [AW-1:0] last_addr,
  output logic          busy,
  output logic          hold,
  output logic          done,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          dump_valid,
  input  logic          dump_ready,
  output logic [AW-1:0] dump_addr,
  output logic [DW-1:0] dump_data
);

  localparam logic [AW-1:0] LAST_REG = AW'(NREG - 1);

  dump_state_e   state_q, state_d;
  logic [AW-1:0] cur_q, cur_d;
  logic [AW-1:0] end_q, end_d;
  logic [AW-1:0] dump_addr_q, dump_addr_d;
  logic [DW-1:0] dump_data_q, dump_data_d;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] range_end;

  always_comb begin
    // A reversed range collapses to a single register; nothing may run past the bank.
    start_addr = (first_addr > LAST_REG) ? LAST_REG : first_addr;
    range_end  = (last_addr < start_addr) ? start_addr : last_addr;
    if (range_end > LAST_REG) begin
      range_end = LAST_REG;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    end_d       = end_q;
    dump_addr_d = dump_addr_q;
    dump_data_d = dump_data_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cur_d   = start_addr;
          end_d   = range_end;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        dump_addr_d = cur_q;
        dump_data_d = rd_data;
        state_d     = ST_SEND;
      end
      ST_SEND: begin
        if (dump_ready) begin
          if ((cur_q == end_q) || (cur_q == LAST_REG)) begin
            state_d = ST_FIN;
          end else begin
            cur_d   = cur_q + 1'b1;
            state_d = ST_READ;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cur_q       <= '0;
      end_q       <= '0;
      dump_addr_q <= '0;
      dump_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      end_q       <= end_d;
      dump_addr_q <= dump_addr_d;
      dump_data_q <= dump_data_d;
    end
  end

  // Status decodes come from the state register alone, so no input reaches them.
  assign busy       = (state_q != ST_IDLE);
  assign hold       = busy;
  assign done       = (state_q == ST_FIN);
  assign dump_valid = (state_q == ST_SEND);
  assign rd_addr    = cur_q;
  assign dump_addr  = dump_addr_q;
  assign dump_data  = dump_data_q;

endmodule

// File: tb/tb_reg_bank_dumper.sv
// Self-checking bench for reg_bank_dumper: a behavioural register bank feeds the read
// port and a queue-based model of the requested range predicts every streamed word.
module tb_reg_bank_dumper;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  first_addr;
  logic [4:0]  last_addr;
  logic        busy;
  logic        hold;
  logic        done;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_addr;
  logic [31:0] dump_data;

  logic [31:0] bank [32];
  assign rd_data = bank[rd_addr];

  int n_checks = 0;
  int n_fail   = 0;

  reg_bank_dumper dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .busy       (busy),
    .hold       (hold),
    .done       (done),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] first;
    logic [4:0] last;
    int         exp_words;
    int         exp_done;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one dump and checks it against the range model. pct is the dump_ready
  // probability in percent; exp_done < 0 skips the latency check; inject pulses
  // start mid-dump and again in the done cycle.
  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int pct,
                          input int exp_done, input bit inject, output int words);
    logic [36:0] exp_q[$];
    logic [36:0] w;
    int          e;
    int          cnt;
    bit          prev_stall;
    logic [4:0]  prev_addr;
    logic [31:0] prev_data;
    bit          seen_done;

    e = (l < f) ? int'(f) : int'(l);
    for (int a = int'(f); a <= e; a++) exp_q.push_back({5'(a), bank[a]});

    words      = 0;
    prev_stall = 1'b0;
    prev_addr  = '0;
    prev_data  = '0;
    seen_done  = 1'b0;
    first_addr = f;
    last_addr  = l;
    start      = 1'b1;
    dump_ready = 1'b0;
    step();
    start = 1'b0;
    cnt   = 1;
    check("busy_after_start", {63'd0, busy}, 64'd1);

    while (cnt < 3000) begin
      check("hold_eq_busy", {63'd0, hold}, {63'd0, busy});
      if (cnt == 2) check("valid_after_e1", {63'd0, dump_valid}, 64'd1);
      if (prev_stall) begin
        check("stall_valid", {63'd0, dump_valid}, 64'd1);
        check("stall_addr", {59'd0, dump_addr}, {59'd0, prev_addr});
        check("stall_data", {32'd0, dump_data}, {32'd0, prev_data});
      end
      start = 1'b0;
      if (inject && cnt == 5) begin
        start      = 1'b1;
        first_addr = 5'd20;
        last_addr  = 5'd2;
      end
      if (done) begin
        seen_done = 1'b1;
        check("done_words_left", 64'(exp_q.size()), 64'd0);
        if (exp_done >= 0) check("done_latency", 64'(cnt), 64'(exp_done));
        break;
      end
      dump_ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
      if (dump_valid && dump_ready) begin
        words++;
        $display("word %0d: addr=%0d data=%08h", words, dump_addr, dump_data);
        if (exp_q.size() == 0) begin
          check("extra_word", 64'd1, 64'd0);
        end else begin
          w = exp_q.pop_front();
          check("word_addr", {59'd0, dump_addr}, {59'd0, w[36:32]});
          check("word_data", {32'd0, dump_data}, {32'd0, w[31:0]});
        end
      end
      prev_stall = dump_valid && !dump_ready;
      prev_addr  = dump_addr;
      prev_data  = dump_data;
      step();
      cnt++;
    end
    if (!seen_done) check("done_timeout", 64'd0, 64'd1);

    // Start during the done cycle must be ignored.
    start = inject;
    dump_ready = 1'b1;
    step();
    start = 1'b0;
    check("idle_after_done_busy", {63'd0, busy}, 64'd0);
    check("single_done", {63'd0, done}, 64'd0);
    step();
    check("still_idle", {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    vec_t tbl[6];
    int   words;
    logic [4:0] rf, rl;

    tbl[0] = '{first: 5'd0,  last: 5'd31, exp_words: 32, exp_done: 65};
    tbl[1] = '{first: 5'd5,  last: 5'd7,  exp_words: 3,  exp_done: 7};
    tbl[2] = '{first: 5'd9,  last: 5'd3,  exp_words: 1,  exp_done: 3};
    tbl[3] = '{first: 5'd31, last: 5'd31, exp_words: 1,  exp_done: 3};
    tbl[4] = '{first: 5'd0,  last: 5'd0,  exp_words: 1,  exp_done: 3};
    tbl[5] = '{first: 5'd30, last: 5'd31, exp_words: 2,  exp_done: 5};

    for (int i = 0; i < 32; i++) bank[i] = 32'(i) * 32'h01010101;
    rst_n      = 1'b0;
    start      = 1'b0;
    first_addr = '0;
    last_addr  = '0;
    dump_ready = 1'b0;
    step();
    step();
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_hold", {63'd0, hold}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_valid", {63'd0, dump_valid}, 64'd0);
    check("rst_rd_addr", {59'd0, rd_addr}, 64'd0);
    check("rst_dump_addr", {59'd0, dump_addr}, 64'd0);
    check("rst_dump_data", {32'd0, dump_data}, 64'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      run_dump(tbl[i].first, tbl[i].last, 100, tbl[i].exp_done, 1'b0, words);
      check("table_word_count", 64'(words), 64'(tbl[i].exp_words));
    end

    // Full dump under 30% back-pressure.
    run_dump(5'd0, 5'd31, 30, -1, 1'b0, words);
    check("bp_word_count", 64'(words), 64'd32);

    // Start pulses mid-dump and in the done cycle.
    run_dump(5'd4, 5'd12, 100, 19, 1'b1, words);
    check("inject_word_count", 64'(words), 64'd9);

    // Random ranges, random bank contents, random back-pressure.
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 32; i++) bank[i] = $urandom;
      rf = 5'($urandom_range(0, 31));
      rl = 5'($urandom_range(0, 31));
      run_dump(rf, rl, 50, -1, 1'b0, words);
      check("rand_word_count", 64'(words),
            64'(((rl < rf) ? int'(rf) : int'(rl)) - int'(rf) + 1));
    end

    // Reset mid-dump right after the word at address 10 is accepted.
    for (int i = 0; i < 32; i++) bank[i] = 32'(i) * 32'h01010101;
    first_addr = 5'd0;
    last_addr  = 5'd31;
    start      = 1'b1;
    dump_ready = 1'b1;
    step();
    start = 1'b0;
    begin
      int guard;
      guard = 0;
      while (!(dump_valid && dump_addr == 5'd10) && guard < 200) begin
        step();
        guard++;
      end
      check("reach_word10", 64'(guard < 200), 64'd1);
    end
    step();
    rst_n = 1'b0;
    step();
    check("abort_outputs", {busy, hold, done, dump_valid, rd_addr, dump_addr, dump_data},
          64'd0);
    rst_n = 1'b1;
    step();
    check("abort_no_done", {62'd0, done, hold}, 64'd0);
    run_dump(5'd0, 5'd3, 100, 9, 1'b0, words);
    check("post_abort_count", 64'(words), 64'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_bank_dumper.md
# reg_bank_dumper

Sequential read-out engine for the 32×32 register bank of the single-cycle MIPS core: the read-side counterpart of the bank initialisation path (write address, write data, write enable, select). On a start pulse it freezes the core, walks a register address range, reads each register through the bank's combinational read port and streams `{address, data}` words out over a valid/ready handshake. It then releases the core and pulses done. It sits beside the register bank, sharing the bank's external-access mux with the initialisation path.

## Interface
Parameters:
- `NREG`, 32: number of registers in the bank.
- `AW`, 5: register address width.
- `DW`, 32: register data width.

Ports:
- `clk`, in, 1: single clock; all state changes on rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `start`, in, 1: one-cycle request to begin a dump; ignored while `busy`=1.
- `first_addr`, in, AW: first register to dump; sampled when `start` is accepted.
- `last_addr`, in, AW: last register to dump; sampled when `start` is accepted.
- `busy`, out, 1: dump in progress.
- `hold`, out, 1: freeze request to the core and bank-mux select for external access; equal to `busy`.
- `done`, out, 1: one-cycle pulse after the last word is accepted.
- `rd_addr`, out, AW: register bank read address.
- `rd_data`, in, DW: register bank read data, combinational from `rd_addr`.
- `dump_valid`, out, 1: output word valid.
- `dump_ready`, in, 1: sink accepts the word.
- `dump_addr`, out, AW: register index of the current word.
- `dump_data`, out, DW: register contents of the current word.

## Operation
- States are `IDLE`, `READ`, `SEND`, `FIN`.
- `IDLE`:
  - On `start`=1: latch `cur`=`first_addr`.
  - Latch `end`=`last_addr`, or `first_addr` if `last_addr`<`first_addr` (no wrap; a single register is dumped).
  - Go to `READ`.
- `READ`:
  - `rd_addr`=`cur`.
  - At the clock edge, capture `dump_addr`←`cur` and `dump_data`←`rd_data`.
  - Go to `SEND`.
- `SEND`:
  - `dump_valid`=1.
  - `dump_addr` and `dump_data` stay stable until the word is accepted (`dump_valid`=1 and `dump_ready`=1).
  - On acceptance: if `cur`==`end`, go to `FIN`. Otherwise `cur`←`cur`+1 and go to `READ`.
  - `cur` never wraps past `NREG`-1.
- `FIN`:
  - `done`=1 for exactly one cycle; go to `IDLE`.
- `busy` and `hold` are 1 in `READ`, `SEND` and `FIN`.
- `start` in any state other than `IDLE` is ignored; it is not queued.
- `dump_ready` while `dump_valid`=0 has no effect.
- Reset values (when `rst_n`=0 at an edge):
  - State `IDLE`.
  - `busy`, `hold`, `done`, `dump_valid` = 0.
  - `rd_addr`, `dump_addr`, `cur`, `end` = 0.
  - `dump_data` = 0.
- Reset mid-dump aborts at once:
  - No `done` pulse.
  - `hold` drops in the cycle after the reset edge.
  - The remaining words are lost.

## Timing
- `start` sampled at edge E0:
  - `busy`/`hold` high after E0 (state `READ`).
  - First `dump_valid` high after E1.
- With `dump_ready` tied high:
  - 2 cycles per register.
  - A full 32-register dump occupies 64 cycles, plus 1 `FIN` cycle.
  - `done` is high during the cycle after the last acceptance edge.
- `rd_addr` is valid for the whole `READ` cycle. The bank must be frozen (`hold`) before `READ`; it is, because `hold` rises with `READ`.
- Back-pressure: each cycle `dump_ready`=0 in `SEND` adds one cycle. There is no bound on the stall.
- `dump_addr`/`dump_data` are registered outputs. `busy`, `hold`, `done` and `dump_valid` are decoded from the state register only, with no combinational path from inputs.
- `start` in the `FIN` cycle is ignored. The earliest new start is accepted at the first `IDLE` edge.

## Structure
- State encodings and the default `NREG`/`AW`/`DW` constants go in the shared MIPS definitions package, alongside the register bank's width constants.
- Single module, no sub-module. Address counter, FSM and output registers are inline.
- The top level muxes `rd_addr` onto the bank's read port, and gates the core clock enable/PC update with `hold`.

## Test plan
- Reset, then a full dump:
  - Initialise the bank with r[i]=i×0x01010101, `dump_ready`=1, `start` with `first_addr`=0, `last_addr`=31.
  - Required: 32 words in order, addr 0..31, data matching r[i]; `done` exactly 65 cycles after the `start` edge; `hold` low afterwards.
- Partial range:
  - `first_addr`=5, `last_addr`=7.
  - Required: exactly 3 words, addr 5/6/7.
  - `first_addr`=9, `last_addr`=3: exactly one word, addr 9.
- Back-pressure:
  - Drive `dump_ready` with a pseudo-random pattern at 30% high during a full dump.
  - Required: words stable while stalled, no duplicates or drops, 32 acceptances, then `done`.
- `start` while busy:
  - Pulse `start` mid-dump, and again during `FIN`.
  - Required: the dump is unaffected, there is only one `done`, and the state is `IDLE` afterwards.
- Reset mid-dump:
  - Assert `rst_n`=0 after word 10 is accepted.
  - Required: next cycle all outputs 0, no `done`, `hold`=0.
  - A new `start` after release dumps from `first_addr` correctly.
- Register 31 boundary:
  - `first_addr`=31, `last_addr`=31.
  - Required: one word, addr 31, `cur` does not wrap, `done` 3 cycles after `start`.
